// File: rtl/mode_select.sv
`default_nettype none
// ============================================================================
//  Module      : mode_select
//  Description : Front-panel waveform mode selector for the DDS function
//                generator. Raw push-buttons are synchronised (2 flops),
//                debounced (level must disagree for DEB_CNT consecutive
//                cycles) and rising-edge detected. Each press event steps
//                the registered mode index, wrapping within 0..NUM_MODES-1.
//
//  Optional    : MODE_PREV_EN - adds the Btn_prev button (own synchroniser,
//                debouncer and edge detector) that steps the mode backwards.
//                Simultaneous next/prev events cancel each other.
//
//  Ports       : Fg_clk       in   system clock, rising-edge active
//                Reset        in   synchronous active-high reset
//                Btn_next     in   raw asynchronous "next mode" button
//                Btn_prev     in   raw "previous mode" button (MODE_PREV_EN)
//                Mode[2:0]    out  current mode index, registered
//                Mode_changed out  one-cycle strobe with each new Mode value
//                Btn_state    out  debounced level of Btn_next, registered
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mode_select #(
    parameter int NUM_MODES = 5,      // 2..8
    parameter int DEB_CNT   = 50000,  // 2..65535
    parameter int CNT_W     = 16      // 2**CNT_W > DEB_CNT
) (
    input  logic       Fg_clk,
    input  logic       Reset,
    input  logic       Btn_next,
`ifdef MODE_PREV_EN
    input  logic       Btn_prev,
`endif
    output logic [2:0] Mode,
    output logic       Mode_changed,
    output logic       Btn_state
);

`ifdef MODE_PREV_EN
    localparam int c_NUM_BTN = 2;
`else
    localparam int c_NUM_BTN = 1;
`endif

    // Terminal debounce count: the level is accepted on the edge where the
    // counter already sits at this value, i.e. after DEB_CNT disagreeing cycles.
    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(DEB_CNT - 1);
    localparam logic [2:0]       c_MODE_LAST = 3'(NUM_MODES - 1);

    // Bit 0 is always the "next" button, bit 1 (when present) the "prev" one.
    logic [c_NUM_BTN-1:0] w_btn_raw;
    logic [c_NUM_BTN-1:0] w_press;

    assign w_btn_raw[0] = Btn_next;
`ifdef MODE_PREV_EN
    assign w_btn_raw[1] = Btn_prev;
`endif

    // ------------------------------------------------------------------
    // Per-button synchroniser, debouncer and press detector
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_btn
            logic             r_sync1;
            logic             r_sync2;
            logic             r_stable;
            logic             r_stable_d;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge Fg_clk) begin
                if (Reset) begin
                    r_sync1    <= 1'b0;
                    r_sync2    <= 1'b0;
                    r_stable   <= 1'b0;
                    r_stable_d <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_sync1    <= w_btn_raw[gi];
                    r_sync2    <= r_sync1;
                    r_stable_d <= r_stable;
                    // A single cycle of agreement restarts the count, so only
                    // an uninterrupted run of DEB_CNT differing samples is taken.
                    if (r_sync2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_stable <= r_sync2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end

            // Rising debounced level only; release and hold give no event.
            assign w_press[gi] = r_stable & ~r_stable_d;

            if (gi == 0) begin : g_state
                assign Btn_state = r_stable;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Mode register
    // ------------------------------------------------------------------
    logic       w_next_evt;
    logic       w_prev_evt;
    logic [2:0] r_mode;
    logic [2:0] w_mode_nxt;
    logic       r_changed;
    logic       w_changed_nxt;

    assign w_next_evt = w_press[0];
`ifdef MODE_PREV_EN
    assign w_prev_evt = w_press[1];
`else
    assign w_prev_evt = 1'b0;
`endif

    always_comb begin
        w_mode_nxt    = r_mode;
        w_changed_nxt = 1'b0;
        // Coincident next/prev events leave the mode untouched.
        if (w_next_evt && !w_prev_evt) begin
            w_mode_nxt    = (r_mode == c_MODE_LAST) ? 3'd0 : r_mode + 3'd1;
            w_changed_nxt = 1'b1;
        end else if (w_prev_evt && !w_next_evt) begin
            w_mode_nxt    = (r_mode == 3'd0) ? c_MODE_LAST : r_mode - 3'd1;
            w_changed_nxt = 1'b1;
        end
    end

    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            r_mode    <= 3'd0;
            r_changed <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_changed <= w_changed_nxt;
        end
    end

    assign Mode         = r_mode;
    assign Mode_changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_mode_select.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mode_select
//  Description : Self-checking bench for mode_select (NUM_MODES=5, DEB_CNT=4).
//                Expected mode values are queued when a press is driven and
//                popped by a monitor whenever Mode_changed is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mode_select;

    localparam int NUM_MODES = 5;
    localparam int DEB_CNT   = 4;
    localparam int CNT_W     = 16;

    logic       Fg_clk;
    logic       Reset;
    logic       Btn_next;
`ifdef MODE_PREV_EN
    logic       Btn_prev;
`endif
    logic [2:0] Mode;
    logic       Mode_changed;
    logic       Btn_state;

    int         n_checks;
    int         n_fail;
    logic [2:0] sb[$];
    logic [2:0] exp_mode;
    logic [7:0] mon_exp;

    mode_select #(
        .NUM_MODES(NUM_MODES),
        .DEB_CNT  (DEB_CNT),
        .CNT_W    (CNT_W)
    ) dut (
        .Fg_clk      (Fg_clk),
        .Reset       (Reset),
        .Btn_next    (Btn_next),
`ifdef MODE_PREV_EN
        .Btn_prev    (Btn_prev),
`endif
        .Mode        (Mode),
        .Mode_changed(Mode_changed),
        .Btn_state   (Btn_state)
    );

    initial Fg_clk = 1'b0;
    always #5 Fg_clk = ~Fg_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; returns at a falling edge (sample/drive point).
    task automatic cyc(input int n);
        repeat (n) @(negedge Fg_clk);
    endtask

    // Monitor: range invariant every cycle, scoreboard pop on each strobe.
    always @(negedge Fg_clk) begin
        chk("mode_range", 8'(Mode < 3'(NUM_MODES)), 8'd1);
        if (Mode_changed === 1'b1) begin
            mon_exp = (sb.size() != 0) ? 8'(sb.pop_front()) : 8'hEE;
            chk("sb_mode", 8'(Mode), mon_exp);
        end
    end

    task automatic do_reset();
        Reset = 1'b1;
        cyc(2);
        chk("rst_mode", 8'(Mode), 8'd0);
        chk("rst_changed", 8'(Mode_changed), 8'd0);
        chk("rst_btn_state", 8'(Btn_state), 8'd0);
        Reset    = 1'b0;
        exp_mode = 3'd0;
    endtask

    // Buttons were raised just before the next rising edge E: debounced level
    // rises at E+DEB_CNT+1, mode updates at E+DEB_CNT+2.
    task automatic await_press(input logic [2:0] m_before, input logic [2:0] m_after,
                               input logic bs_exp, input logic chg);
        cyc(DEB_CNT + 1);
        chk("btn_state_early", 8'(Btn_state), 8'd0);
        chk("mode_early", 8'(Mode), 8'(m_before));
        cyc(1);
        chk("btn_state_rise", 8'(Btn_state), 8'(bs_exp));
        chk("mode_hold", 8'(Mode), 8'(m_before));
        cyc(1);
        chk("mode_update", 8'(Mode), 8'(m_after));
        chk("changed_pulse", 8'(Mode_changed), 8'(chg));
        cyc(1);
        chk("changed_clear", 8'(Mode_changed), 8'd0);
    endtask

    task automatic press(input logic nxt, input logic prv);
        logic [2:0] m_after;
        logic       chg;
        m_after = exp_mode;
        chg     = nxt ^ prv;
        if (nxt && !prv)
            m_after = (exp_mode == 3'(NUM_MODES - 1)) ? 3'd0 : exp_mode + 3'd1;
        else if (prv && !nxt)
            m_after = (exp_mode == 3'd0) ? 3'(NUM_MODES - 1) : exp_mode - 3'd1;
        if (chg) sb.push_back(m_after);
        Btn_next = nxt;
`ifdef MODE_PREV_EN
        Btn_prev = prv;
`endif
        await_press(exp_mode, m_after, nxt, chg);
        Btn_next = 1'b0;
`ifdef MODE_PREV_EN
        Btn_prev = 1'b0;
`endif
        cyc(DEB_CNT + 4);
        chk("release_btn_state", 8'(Btn_state), 8'd0);
        chk("release_mode", 8'(Mode), 8'(m_after));
        exp_mode = m_after;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_mode = 3'd0;
        Btn_next = 1'b1;
`ifdef MODE_PREV_EN
        Btn_prev = 1'b0;
`endif
        // Reset held with the button pressed; no event on release until the
        // full debounce latency has elapsed.
        Reset = 1'b1;
        cyc(1);
        chk("rst1_mode", 8'(Mode), 8'd0);
        chk("rst1_changed", 8'(Mode_changed), 8'd0);
        chk("rst1_btn_state", 8'(Btn_state), 8'd0);
        cyc(1);
        chk("rst2_mode", 8'(Mode), 8'd0);
        chk("rst2_changed", 8'(Mode_changed), 8'd0);
        chk("rst2_btn_state", 8'(Btn_state), 8'd0);
        Reset = 1'b0;
        sb.push_back(3'd1);
        await_press(3'd0, 3'd1, 1'b1, 1'b1);
        exp_mode = 3'd1;

        // Long hold gives exactly one event.
        cyc(100);
        chk("hold_mode", 8'(Mode), 8'd1);
        chk("hold_btn_state", 8'(Btn_state), 8'd1);
        Btn_next = 1'b0;
        cyc(DEB_CNT + 4);
        chk("hold_release_state", 8'(Btn_state), 8'd0);
        chk("hold_release_mode", 8'(Mode), 8'd1);

        // Bounce: 3 high, 1 low, 3 high never reaches DEB_CNT agreement.
        do_reset();
        Btn_next = 1'b1; cyc(3);
        Btn_next = 1'b0; cyc(1);
        Btn_next = 1'b1; cyc(3);
        Btn_next = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("bounce_btn_state", 8'(Btn_state), 8'd0);
            chk("bounce_changed", 8'(Mode_changed), 8'd0);
            cyc(1);
        end
        chk("bounce_mode", 8'(Mode), 8'd0);

        // Five clean presses wrap 1,2,3,4,0.
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
        chk("wrap_mode", 8'(Mode), 8'd0);

        // Reset while the debounce counter is at its last step.
        Btn_next = 1'b1;
        cyc(DEB_CNT + 1);
        Reset = 1'b1;
        cyc(1);
        chk("midrst_mode", 8'(Mode), 8'd0);
        chk("midrst_btn_state", 8'(Btn_state), 8'd0);
        chk("midrst_changed", 8'(Mode_changed), 8'd0);
        Reset    = 1'b0;
        exp_mode = 3'd0;
        sb.push_back(3'd1);
        await_press(3'd0, 3'd1, 1'b1, 1'b1);
        exp_mode = 3'd1;
        Btn_next = 1'b0;
        cyc(DEB_CNT + 4);
        chk("midrst_final_mode", 8'(Mode), 8'd1);

`ifdef MODE_PREV_EN
        do_reset();
        press(1'b0, 1'b1);
        chk("prev_wrap", 8'(Mode), 8'd4);
        press(1'b1, 1'b1);
        chk("both_mode", 8'(Mode), 8'd4);
`endif

        cyc(2);
        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
